// File: rtl/keypad_scanner_if.sv
// Key-code FIFO read side of the keypad scanner: pop handshake, status and interrupt.
// master = scanner, slave = I/O register logic that pops codes.
interface keypad_scanner_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             keyRdEn;
  logic             keyValid;
  logic [4:0]       keyCode;
  logic [CNT_W-1:0] keyCount;
  logic             overflow;
  logic             ovfClear;
  logic             keyPressInt;

  modport master (
    input  keyRdEn, ovfClear,
    output keyValid, keyCode, keyCount, overflow, keyPressInt
  );

  modport slave (
    output keyRdEn, ovfClear,
    input  keyValid, keyCode, keyCount, overflow, keyPressInt
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a key-code FIFO.
// Optional feature macro KEYPAD_RELEASE_EVT_EN: also queue debounced releases (KeyCode[4]=1).
module keypad_scanner #(
  parameter int SCAN_DWELL     = 14_999,
  parameter int DEBOUNCE_COUNT = 224_999,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  output logic [3:0]       o_col,
  input  logic [3:0]       i_row,
  keypad_scanner_if.master bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (SCAN_DWELL > DEBOUNCE_COUNT) ? SCAN_DWELL : DEBOUNCE_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'(SCAN_DWELL);
  localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEBOUNCE_COUNT);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PUSH,
    S_WAIT_REL,
    S_REL_DB
`ifdef KEYPAD_RELEASE_EVT_EN
    , S_REL_PUSH
`endif
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_colIdx;
  logic [1:0]       r_rowIdx;
  logic [3:0]       r_rowPat;
  logic [3:0]       r_rowMeta;
  logic [3:0]       r_rowSync;
  logic [3:0]       r_col;

  logic [4:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic             r_pressInt;

  logic [1:0] w_lowRow;
  logic       w_push;
  logic       w_relFlag;
  logic [4:0] w_pushCode;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_pushOk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rowMeta <= 4'hF;
      r_rowSync <= 4'hF;
    end else begin
      r_rowMeta <= i_row;
      r_rowSync <= r_rowMeta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_col <= 4'hF;
    else          r_col <= i_enable ? ~(4'b0001 << r_colIdx) : 4'hF;
  end

  // With several rows closed on one column, the lowest row index is reported.
  always_comb begin
    w_lowRow = 2'd3;
    if      (!r_rowSync[0]) w_lowRow = 2'd0;
    else if (!r_rowSync[1]) w_lowRow = 2'd1;
    else if (!r_rowSync[2]) w_lowRow = 2'd2;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_SCAN;
      r_cnt    <= '0;
      r_colIdx <= 2'd0;
      r_rowIdx <= 2'd0;
      r_rowPat <= 4'hF;
    end else if (!i_enable) begin
      r_state  <= S_SCAN;
      r_cnt    <= '0;
      r_colIdx <= 2'd0;
    end else begin
      case (r_state)
        S_SCAN: begin
          if (r_cnt == DWELL_TC) begin
            r_cnt <= '0;
            if (r_rowSync == 4'hF) begin
              r_colIdx <= r_colIdx + 2'd1;
            end else begin
              r_rowIdx <= w_lowRow;
              r_rowPat <= r_rowSync;
              r_state  <= S_DEBOUNCE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DEBOUNCE: begin
          if (r_rowSync != r_rowPat) begin
            r_cnt   <= '0;
            r_state <= S_SCAN;
          end else if (r_cnt == DEB_TC) begin
            r_cnt   <= '0;
            r_state <= S_PUSH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_PUSH: r_state <= S_WAIT_REL;
        S_WAIT_REL: begin
          if (r_rowSync == 4'hF) begin
            r_cnt   <= '0;
            r_state <= S_REL_DB;
          end
        end
        S_REL_DB: begin
          if (r_rowSync != 4'hF) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_REL;
          end else if (r_cnt == DEB_TC) begin
            r_cnt <= '0;
`ifdef KEYPAD_RELEASE_EVT_EN
            r_state <= S_REL_PUSH;
`else
            r_colIdx <= r_colIdx + 2'd1;
            r_state  <= S_SCAN;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef KEYPAD_RELEASE_EVT_EN
        S_REL_PUSH: begin
          r_colIdx <= r_colIdx + 2'd1;
          r_state  <= S_SCAN;
        end
`endif
        default: r_state <= S_SCAN;
      endcase
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  assign w_push    = i_enable && ((r_state == S_PUSH) || (r_state == S_REL_PUSH));
  assign w_relFlag = (r_state == S_REL_PUSH);
`else
  assign w_push    = i_enable && (r_state == S_PUSH);
  assign w_relFlag = 1'b0;
`endif

  assign w_pushCode = {w_relFlag, r_rowIdx, r_colIdx};
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_pop      = bus.keyRdEn && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_pushOk   = w_push && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_pressInt <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_mem[r_wrPtr] <= w_pushCode;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (bus.ovfClear)          r_overflow <= 1'b0;
      r_pressInt <= w_pushOk;
    end
  end

  assign o_col           = r_col;
  assign bus.keyValid    = !w_empty;
  assign bus.keyCode     = r_mem[r_rdPtr];
  assign bus.keyCount    = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.keyPressInt = r_pressInt;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a behavioural 4x4 key matrix.
// Release-event checks are built when KEYPAD_RELEASE_EVT_EN is defined.
module tb_keypad_scanner;
  localparam int SCAN_DWELL     = 3;
  localparam int DEBOUNCE_COUNT = 9;
  localparam int FIFO_DEPTH     = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys   = '0;

  int checks     = 0;
  int errors     = 0;
  int pulseTotal = 0;

  keypad_scanner_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus();

  keypad_scanner #(
    .SCAN_DWELL(SCAN_DWELL),
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_enable(enable),
    .o_col(col),
    .i_row(row),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // keys[r*4+c] closed pulls row r low whenever column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
  end

  always @(negedge clk) if (bus.keyPressInt === 1'b1) pulseTotal++;

  task automatic doPop;
    bus.keyRdEn = 1'b1;
    @(negedge clk);
    bus.keyRdEn = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (bus.keyValid === 1'b1 && n < 10) begin
      doPop();
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (col !== 4'hF) begin errors++; $display("[TB] FAIL reset_col: got %h, expected f", col); end
    checks++; if (bus.keyValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", bus.keyValid); end
    checks++; if (bus.keyCount !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d, expected 0", bus.keyCount); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b, expected 0", bus.overflow); end
    checks++; if (bus.keyPressInt !== 1'b0) begin errors++; $display("[TB] FAIL reset_int: got %b, expected 0", bus.keyPressInt); end
    checks++; if (bus.keyCode !== 5'h00) begin errors++; $display("[TB] FAIL reset_code: got %h, expected 00", bus.keyCode); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan;
    logic [3:0] expCol;
    int flagErr = 0;
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      expCol = ~(4'b0001 << (k / 4));
      checks++;
      if (col !== expCol) begin errors++; $display("[TB] FAIL scan_col[%0d]: got %b, expected %b", k, col, expCol); end
      if (bus.keyValid !== 1'b0 || bus.overflow !== 1'b0) flagErr++;
    end
    checks++;
    if (flagErr != 0) begin errors++; $display("[TB] FAIL scan_idle_flags: got %0d cycles with valid/overflow set, expected 0", flagErr); end
  endtask

  task automatic test_press;
    int p0 = pulseTotal;
    keys[2*4+1] = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (pulseTotal - p0 != 1) begin errors++; $display("[TB] FAIL press_pulses: got %0d, expected 1", pulseTotal - p0); end
    checks++; if (bus.keyValid !== 1'b1) begin errors++; $display("[TB] FAIL press_valid: got %b, expected 1", bus.keyValid); end
    checks++; if (bus.keyCount !== 3'd1) begin errors++; $display("[TB] FAIL press_count: got %0d, expected 1", bus.keyCount); end
    checks++; if (bus.keyCode !== 5'h09) begin errors++; $display("[TB] FAIL press_code: got %h, expected 09", bus.keyCode); end
    keys = '0;
    repeat (20) @(negedge clk);
`ifdef KEYPAD_RELEASE_EVT_EN
    checks++; if (bus.keyCount !== 3'd2) begin errors++; $display("[TB] FAIL press_rel_count: got %0d, expected 2", bus.keyCount); end
    doPop();
    checks++; if (bus.keyCode !== 5'h19) begin errors++; $display("[TB] FAIL press_rel_code: got %h, expected 19", bus.keyCode); end
`else
    checks++; if (bus.keyCount !== 3'd1) begin errors++; $display("[TB] FAIL press_norel_count: got %0d, expected 1", bus.keyCount); end
    doPop();
    checks++; if (bus.keyValid !== 1'b0) begin errors++; $display("[TB] FAIL press_pop_valid: got %b, expected 0", bus.keyValid); end
`endif
    drain();
  endtask

  task automatic test_bounce;
    int n = 0;
    int p0 = pulseTotal;
    while (col == 4'b1101 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (col != 4'b1101 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n >= 40) begin errors++; $display("[TB] FAIL bounce_sync: got timeout, expected col 1101"); end
    for (int t = 0; t < 20; t++) begin
      keys[2*4+1] = ((t / 3) % 2 == 0);
      checks++;
      if (col !== 4'b1101) begin errors++; $display("[TB] FAIL bounce_col[%0d]: got %b, expected 1101", t, col); end
      @(negedge clk);
    end
    keys = '0;
    n = 0;
    while (col == 4'b1101 && n < 40) begin @(negedge clk); n++; end
    checks++; if (col !== 4'b1011) begin errors++; $display("[TB] FAIL bounce_next_col: got %b, expected 1011", col); end
    repeat (20) @(negedge clk);
    checks++; if (bus.keyCount !== 3'd0) begin errors++; $display("[TB] FAIL bounce_count: got %0d, expected 0", bus.keyCount); end
    checks++; if (pulseTotal - p0 != 0) begin errors++; $display("[TB] FAIL bounce_pulses: got %0d, expected 0", pulseTotal - p0); end
  endtask

  task automatic test_multi_row;
    int n = 0;
    keys[0*4+2] = 1'b1;
    keys[3*4+2] = 1'b1;
    while (bus.keyValid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++; if (n >= 60) begin errors++; $display("[TB] FAIL multi_timeout: got no push, expected push"); end
    checks++; if (bus.keyCode !== 5'h02) begin errors++; $display("[TB] FAIL multi_code: got %h, expected 02", bus.keyCode); end
    keys = '0;
    repeat (20) @(negedge clk);
    drain();
  endtask

`ifdef KEYPAD_RELEASE_EVT_EN
  task automatic test_release_evt;
    int n = 0;
    keys[1*4+3] = 1'b1;
    while (bus.keyValid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++; if (bus.keyCode !== 5'h07) begin errors++; $display("[TB] FAIL rel_press_code: got %h, expected 07", bus.keyCode); end
    keys = '0;
    n = 0;
    while (bus.keyCount !== 3'd2 && n < 30) begin @(negedge clk); n++; end
    checks++; if (bus.keyCount !== 3'd2) begin errors++; $display("[TB] FAIL rel_count: got %0d, expected 2", bus.keyCount); end
    doPop();
    checks++; if (bus.keyCode !== 5'h17) begin errors++; $display("[TB] FAIL rel_code: got %h, expected 17", bus.keyCode); end
    doPop();
    checks++; if (bus.keyValid !== 1'b0) begin errors++; $display("[TB] FAIL rel_empty: got %b, expected 0", bus.keyValid); end
    repeat (10) @(negedge clk);
  endtask
`endif

  task automatic test_overflow;
    int keyIdx [5] = '{0, 5, 10, 15, 1};
    logic [4:0] expCodes [4];
    int p0 = pulseTotal;
`ifdef KEYPAD_RELEASE_EVT_EN
    expCodes = '{5'h00, 5'h10, 5'h05, 5'h15};
`else
    expCodes = '{5'h00, 5'h05, 5'h0A, 5'h0F};
`endif
    for (int i = 0; i < 5; i++) begin
      keys = '0;
      keys[keyIdx[i]] = 1'b1;
      repeat (40) @(negedge clk);
      keys = '0;
      repeat (20) @(negedge clk);
    end
    checks++; if (bus.keyCount !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count: got %0d, expected 4", bus.keyCount); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b, expected 1", bus.overflow); end
    checks++; if (pulseTotal - p0 != 4) begin errors++; $display("[TB] FAIL ovf_pulses: got %0d, expected 4", pulseTotal - p0); end
    bus.ovfClear = 1'b1;
    @(negedge clk);
    bus.ovfClear = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b, expected 0", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.keyCode !== expCodes[i]) begin errors++; $display("[TB] FAIL ovf_order[%0d]: got %h, expected %h", i, bus.keyCode, expCodes[i]); end
      doPop();
    end
    checks++; if (bus.keyValid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty_valid: got %b, expected 0", bus.keyValid); end
    doPop();
    checks++; if (bus.keyCount !== 3'd0) begin errors++; $display("[TB] FAIL empty_pop_count: got %0d, expected 0", bus.keyCount); end
  endtask

  task automatic test_enable_drop;
    int n = 0;
    int p0 = pulseTotal;
    while (col == 4'b0111 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (col != 4'b0111 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n >= 40) begin errors++; $display("[TB] FAIL endrop_sync: got timeout, expected col 0111"); end
    keys[1*4+3] = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (col !== 4'hF) begin errors++; $display("[TB] FAIL endrop_col: got %b, expected 1111", col); end
    repeat (20) @(negedge clk);
    checks++; if (bus.keyCount !== 3'd0) begin errors++; $display("[TB] FAIL endrop_count: got %0d, expected 0", bus.keyCount); end
    checks++; if (pulseTotal - p0 != 0) begin errors++; $display("[TB] FAIL endrop_pulses: got %0d, expected 0", pulseTotal - p0); end
    keys = '0;
    enable = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (bus.keyCount !== 3'd0) begin errors++; $display("[TB] FAIL endrop_resume_count: got %0d, expected 0", bus.keyCount); end
  endtask

  task automatic test_async_reset;
    logic [2:0] expCount;
`ifdef KEYPAD_RELEASE_EVT_EN
    expCount = 3'd2;
`else
    expCount = 3'd1;
`endif
    keys[0] = 1'b1;
    repeat (40) @(negedge clk);
    keys = '0;
    repeat (20) @(negedge clk);
    checks++; if (bus.keyCount !== expCount) begin errors++; $display("[TB] FAIL arst_pre_count: got %0d, expected %0d", bus.keyCount, expCount); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.keyCount !== 3'd0) begin errors++; $display("[TB] FAIL arst_count: got %0d, expected 0", bus.keyCount); end
    checks++; if (bus.keyValid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid: got %b, expected 0", bus.keyValid); end
    checks++; if (col !== 4'hF) begin errors++; $display("[TB] FAIL arst_col: got %b, expected 1111", col); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.keyRdEn  = 1'b0;
    bus.ovfClear = 1'b0;
    test_reset();
    test_scan();
    test_press();
    test_bounce();
    test_multi_row();
`ifdef KEYPAD_RELEASE_EVT_EN
    test_release_evt();
`endif
    test_overflow();
    test_enable_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad scanner for a 4x4 key matrix, the input-side counterpart of the dynamic-scan seven-segment driver in the basic key/display peripheral. It drives one column low at a time, samples the four pulled-up rows, and debounces both press and release. Each debounced press (and, optionally, each release) is queued as a key code in a small FIFO with an interrupt pulse. It sits in the I/O clock domain beside the key/display block, and the I/O register logic pops codes from it.

## Interface
- SCAN_DWELL, 14_999: cycles per column minus one (1 ms at 15 MHz); minimum 3.
- DEBOUNCE_COUNT, 224_999: stable-cycle count minus one (15 ms at 15 MHz).
- FIFO_DEPTH, 4: key-code FIFO entries; power of two, at least 2.

Ports:
- Clock  in  1  I/O clock; all logic is on its rising edge.
- Reset  in  1  Asynchronous, active-low.
- Enable  in  1  1 = scanning; 0 = scanning halted and Col driven to 4'hF.
- Col  out  4  Column drive; 0 = column selected, 1 = released.
- Row  in  4  Raw row inputs, asynchronous; 0 = key closed.
- KeyRdEn  in  1  Pops the FIFO head; ignored when the FIFO is empty.
- KeyValid  out  1  FIFO is not empty.
- KeyCode  out  5  FIFO head; [4] = release flag, [3:0] = row*4+col.
- KeyCount  out  $clog2(FIFO_DEPTH)+1  Number of entries in the FIFO.
- Overflow  out  1  Sticky flag; set when a push is dropped.
- OvfClear  in  1  Clears Overflow.
- KeyPressInt  out  1  One-cycle pulse, one cycle after each accepted push.

## Operation
- Row is synchronized through two flip-flops per bit, reset value 1. The result is called RowS.
- Col is registered:
  - Enable=1: Col = ~(1<<ColIdx).
  - Enable=0: Col = 4'hF.
- FSM states:
  - S_SCAN: the dwell counter runs 0..SCAN_DWELL. At the terminal count, RowS is sampled.
    - If RowS == 4'hF, ColIdx increments (wrapping 3->0) and the counter restarts.
    - Otherwise RowIdx = the lowest index with a 0 bit, RowPat = RowS, and the FSM goes to S_DEBOUNCE. ColIdx is held.
  - S_DEBOUNCE: the counter runs 0..DEBOUNCE_COUNT while RowS == RowPat.
    - If RowS != RowPat, the counter clears and the FSM returns to S_SCAN on the same column (a bounce).
    - At the terminal count, the FSM goes to S_PUSH.
  - S_PUSH: one cycle. Pushes {1'b0, RowIdx, ColIdx}, then goes to S_WAIT_REL.
  - S_WAIT_REL: waits for RowS == 4'hF, then goes to S_REL_DB with the counter cleared.
  - S_REL_DB: the counter runs 0..DEBOUNCE_COUNT while RowS == 4'hF.
    - Any 0 bit in RowS sends the FSM back to S_WAIT_REL.
    - At the terminal count: if the release event is enabled, the FSM goes to S_REL_PUSH. Otherwise ColIdx increments and the FSM goes to S_SCAN.
  - S_REL_PUSH (only when KEYPAD_RELEASE_EVT_EN is defined): pushes {1'b1, RowIdx, ColIdx}, increments ColIdx, goes to S_SCAN.
- Enable=0 in any state forces the FSM to S_SCAN with ColIdx=0 and counters cleared. No push occurs; FIFO contents are retained.
- FIFO push/pop rules:
  - Push when full with no pop in the same cycle: the code is dropped, Overflow is set, and no interrupt fires.
  - Push and pop in the same cycle when full: both are performed and Overflow is unchanged.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- OvfClear in the same cycle as an overflow event: the set wins.
- Reset values:
  - Col=4'hF; KeyValid=0; KeyCount=0; Overflow=0; KeyPressInt=0.
  - KeyCode=5'h00; FIFO storage is cleared.
  - FSM=S_SCAN; ColIdx=0; counters=0.

## Timing
- Row to RowS latency: 2 cycles. A SCAN_DWELL of at least 3 guarantees the sample reflects the current column.
- Press latency: key stable at the sample point -> S_DEBOUNCE. After DEBOUNCE_COUNT+1 further stable cycles -> S_PUSH. KeyValid and KeyCount update on the clock edge ending S_PUSH. KeyPressInt is high for the following cycle.
- KeyCode is combinational from the head entry and valid whenever KeyValid=1. A pop takes effect on the edge on which KeyRdEn is sampled.
- Reset assertion mid-operation clears everything immediately and asynchronously. There is no partial push.

## Configuration
- KEYPAD_RELEASE_EVT_EN defined:
  - The S_REL_PUSH state exists.
  - Every debounced release pushes a code with KeyCode[4]=1 and pulses KeyPressInt.
- Not defined:
  - Only presses are queued.
  - KeyCode[4] is always 0.
  - S_REL_PUSH is not built.

## Test plan
All scenarios use SCAN_DWELL=3, DEBOUNCE_COUNT=9, FIFO_DEPTH=4 unless stated.

- Reset, then Enable=1, no keys -> Col cycles 1110, 1101, 1011, 0111, each for 4 cycles. KeyValid=0 and Overflow=0 throughout.
- Hold row 2 low while Col[1]=0 for 40 cycles -> exactly one push of KeyCode=5'h09. KeyPressInt pulses once, and KeyCount=1.
- Row 2 toggles every 3 cycles for 20 cycles during debounce -> no push. The FSM returns to S_SCAN on column 1.
- Hold row 0 and row 3 low together on column 2 -> KeyCode=5'h02 (lowest row wins).
- Queue 5 presses without KeyRdEn -> KeyCount=4, Overflow=1, and exactly 4 KeyPressInt pulses. Then OvfClear -> Overflow=0; pop 4 times -> codes come out in FIFO order and KeyValid=0.
- With KEYPAD_RELEASE_EVT_EN defined: press then release key (1,3) -> codes 5'h07 then 5'h17. Drop Enable mid-debounce -> Col=4'hF next cycle and no push.
